// File: rtl/datastream_pkg.sv
// Shared types and helpers for the datastream framer and its bench scoreboard.
// DATASTREAM_FRAMER_CHECKSUM_EN adds one checksum beat to every frame.
package datastream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Total output beats per frame, including the checksum beat when it is built in.
    function automatic int frame_words(input int windowsize, input int framelen);
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
        return windowsize + framelen + 1;
`else
        return windowsize + framelen;
`endif
    endfunction

endpackage

// File: rtl/datastream_framer_if.sv
// Payload-in / framed-stream-out handshake bundle of the datastream framer.
// master = the framer itself, slave = the payload source and downstream sink.
interface datastream_framer_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] data_i;
    logic                valid_i;
    logic                ready_o;
    logic [DATASIZE-1:0] data_o;
    logic                valid_o;
    logic                ready_i;
    logic                frame_o;

    modport master (
        input  data_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o,
        output frame_o
    );

    modport slave (
        output data_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        input  frame_o
    );
endinterface

// File: rtl/datastream_out_reg.sv
// Registered valid/ready output stage that holds its word until the sink accepts it.
module datastream_out_reg #(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load,
    input  logic [DATASIZE-1:0] din,
    input  logic                frame_in,
    input  logic                ready_i,
    output logic [DATASIZE-1:0] data_o,
    output logic                valid_o,
    output logic                frame_o,
    output logic                slot_free
);

    assign slot_free = !valid_o || ready_i;

    // A free slot with nothing to load drops valid so an accepted word is never repeated.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            frame_o <= 1'b0;
        end else if (slot_free) begin
            valid_o <= load;
            frame_o <= load && frame_in;
            if (load) begin
                data_o <= din;
            end
        end
    end

endmodule

// File: rtl/datastream_framer.sv
// Builds frames of WINDOWSIZE sync words followed by FRAMELEN payload words.
// Optional DATASTREAM_FRAMER_CHECKSUM_EN appends the mod-2^DATASIZE payload sum.
module datastream_framer
    import datastream_pkg::*;
#(
    parameter int                  DATASIZE   = 8,
    parameter int                  WINDOWSIZE = 4,
    parameter int                  FRAMELEN   = 16,
    parameter logic [DATASIZE-1:0] SYNC_WORD  = DATASIZE'(SYNC_WORD_DEFAULT)
) (
    input logic                 clk_i,
    input logic                 rst_i,
    datastream_framer_if.master bus
);

    // state   | meaning
    // IDLE    | no frame open; first sync word loads when payload is offered
    // HEADER  | emitting the remaining sync words, independent of valid_i
    // PAYLOAD | forwarding FRAMELEN payload words, bubbles allowed
    // CHECK   | emitting the payload checksum word (checksum builds only)

    localparam int HW = $clog2(WINDOWSIZE + 1);
    localparam int PW = $clog2(FRAMELEN + 1);

    state_t              state;
    state_t              state_nxt;
    logic [HW-1:0]       hdr_cnt;
    logic [HW-1:0]       hdr_nxt;
    logic [PW-1:0]       pay_cnt;
    logic [PW-1:0]       pay_nxt;
    logic                load;
    logic                frame_in;
    logic [DATASIZE-1:0] din;
    logic                slot_free;
    logic                in_xfer;
    logic [DATASIZE-1:0] data_q;
    logic                valid_q;
    logic                frame_q;
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
    logic [DATASIZE-1:0] sum;
    logic [DATASIZE-1:0] sum_nxt;
`endif

    assign bus.ready_o = (state == PAYLOAD) && slot_free;
    assign in_xfer     = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            hdr_cnt <= '0;
            pay_cnt <= '0;
        end else begin
            state   <= state_nxt;
            hdr_cnt <= hdr_nxt;
            pay_cnt <= pay_nxt;
        end
    end

`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sum <= '0;
        end else begin
            sum <= sum_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        hdr_nxt   = hdr_cnt;
        pay_nxt   = pay_cnt;
        load      = 1'b0;
        frame_in  = 1'b0;
        din       = SYNC_WORD;
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            IDLE: begin
                if (bus.valid_i && slot_free) begin
                    load      = 1'b1;
                    frame_in  = 1'b1;
                    hdr_nxt   = HW'(1);
                    pay_nxt   = '0;
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
                    sum_nxt   = '0;
`endif
                    state_nxt = (WINDOWSIZE == 1) ? PAYLOAD : HEADER;
                end
            end
            HEADER: begin
                if (slot_free) begin
                    load    = 1'b1;
                    hdr_nxt = hdr_cnt + HW'(1);
                    if (hdr_nxt == HW'(WINDOWSIZE)) begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_xfer) begin
                    load    = 1'b1;
                    din     = bus.data_i;
                    pay_nxt = pay_cnt + PW'(1);
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
                    sum_nxt = sum + bus.data_i;
`endif
                    if (pay_nxt == PW'(FRAMELEN)) begin
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
                        state_nxt = CHECK;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
            CHECK: begin
                if (slot_free) begin
                    load      = 1'b1;
                    din       = sum;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    datastream_out_reg #(
        .DATASIZE (DATASIZE)
    ) u_out_reg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (load),
        .din       (din),
        .frame_in  (frame_in),
        .ready_i   (bus.ready_i),
        .data_o    (data_q),
        .valid_o   (valid_q),
        .frame_o   (frame_q),
        .slot_free (slot_free)
    );

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_datastream_framer.sv
// Directed table-driven bench for datastream_framer (WINDOWSIZE=4, FRAMELEN=3).
// Follows DATASTREAM_FRAMER_CHECKSUM_EN so the same bench covers both builds.
module tb_datastream_framer;
    import datastream_pkg::*;

    localparam int DW = 8;
    localparam int WS = 4;
    localparam int FL = 3;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef DATASTREAM_FRAMER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    datastream_framer_if #(.DATASIZE(DW)) bus ();

    datastream_framer #(
        .DATASIZE   (DW),
        .WINDOWSIZE (WS),
        .FRAMELEN   (FL),
        .SYNC_WORD  (SYNC)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // One row = one clock: inputs, ready_o before the edge, registered outputs after it.
    typedef struct {
        logic       vi;
        logic [7:0] d;
        logic       ri;
        logic       rst;
        logic       er;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic vi, input logic [7:0] d, input logic ri, input logic rst,
                       input logic er, input logic ev, input logic [7:0] ed, input logic ef);
        vec_t v;
        v.vi = vi; v.d = d; v.ri = ri; v.rst = rst;
        v.er = er; v.ev = ev; v.ed = ed; v.ef = ef;
        vecs.push_back(v);
    endtask

    // Four unstalled header beats; only the first carries frame_o.
    task automatic add_hdr(input logic vi, input logic [7:0] d);
        add(vi, d, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b1);
        for (int k = 1; k < WS; k++) add(vi, d, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b0);
    endtask

    task automatic add_pay(input logic [7:0] d);
        add(1'b1, d, 1'b1, 1'b1, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic add_ck(input logic vi, input logic [7:0] d, input logic [7:0] sum);
        if (CK) add(vi, d, 1'b1, 1'b1, 1'b0, 1'b1, sum, 1'b0);
    endtask

    task automatic add_idle();
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] pay[3];
    logic [7:0] got[$];
    logic [7:0] exp_w[$];

    initial begin
        // single frame, valid_i held through the header
        add_hdr(1'b1, 8'h01);
        add_pay(8'h01); add_pay(8'h02); add_pay(8'h03);
        add_ck(1'b0, 8'h00, 8'h06);
        add_idle();
        // backpressure on the second header word
        add(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b1);
        add(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, SYNC, 1'b0);
        add(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b0);
        add(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, SYNC, 1'b0);
        add_pay(8'h01); add_pay(8'h02); add_pay(8'h03);
        add_ck(1'b0, 8'h00, 8'h06);
        add_idle();
        // input bubble plus payload stall with valid_i high
        add_hdr(1'b1, 8'h01);
        add_pay(8'h01);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        add_pay(8'h02);
        add(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
        add_pay(8'h03);
        add_ck(1'b0, 8'h00, 8'h06);
        add_idle();
        // reset mid-payload, then a fresh frame
        add_hdr(1'b1, 8'h01);
        add_pay(8'h01);
        add(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add_hdr(1'b1, 8'h02);
        add_pay(8'h02); add_pay(8'h03); add_pay(8'h04);
        add_ck(1'b0, 8'h00, 8'h09);
        add_idle();
        // back-to-back frames, sync-valued payload passed through
        add_hdr(1'b1, 8'h11);
        add_pay(8'h11); add_pay(8'hA5); add_pay(8'h13);
        add_ck(1'b1, 8'h14, 8'hC9);
        add_hdr(1'b1, 8'h14);
        add_pay(8'h14); add_pay(8'h15); add_pay(8'h16);
        add_ck(1'b0, 8'h00, 8'h3F);
        add_idle();

        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.ready_i = 1'b1;
        rst_i       = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid", 32'(bus.valid_o), 32'd0);
        check("reset_frame", 32'(bus.frame_o), 32'd0);
        check("reset_data", 32'(bus.data_o), 32'd0);
        check("reset_ready", 32'(bus.ready_o), 32'd0);
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            bus.valid_i = vecs[i].vi;
            bus.data_i  = vecs[i].d;
            bus.ready_i = vecs[i].ri;
            rst_i       = vecs[i].rst;
            #2;
            check($sformatf("row%0d_ready", i), 32'(bus.ready_o), 32'(vecs[i].er));
            @(posedge clk_i);
            #1;
            check($sformatf("row%0d_valid", i), 32'(bus.valid_o), 32'(vecs[i].ev));
            if (vecs[i].ev || !vecs[i].rst) begin
                check($sformatf("row%0d_data", i), 32'(bus.data_o), 32'(vecs[i].ed));
                check($sformatf("row%0d_frame", i), 32'(bus.frame_o), 32'(vecs[i].ef));
            end
        end
        rst_i = 1'b1;

        // checksum frame with a wrapping sum, collected by a small scoreboard
        pay[0] = 8'hFF; pay[1] = 8'h02; pay[2] = 8'h03;
        for (int k = 0; k < WS; k++) exp_w.push_back(SYNC);
        for (int k = 0; k < FL; k++) exp_w.push_back(pay[k]);
        if (CK) exp_w.push_back(8'h04);
        begin
            int  idx = 0;
            int  cyc = 0;
            int  n_frame = 0;
            bit  started = 1'b0;
            bit  done = 1'b0;
            bit  xfer;
            while (!done && cyc < 40) begin
                bus.valid_i = (idx < FL);
                bus.data_i  = (idx < FL) ? pay[idx] : 8'h00;
                bus.ready_i = 1'b1;
                #2;
                xfer = bus.valid_i && bus.ready_o;
                @(posedge clk_i);
                #1;
                cyc++;
                if (xfer) idx++;
                if (bus.valid_o) begin
                    got.push_back(bus.data_o);
                    if (bus.frame_o) n_frame++;
                    started = 1'b1;
                end else if (started) begin
                    done = 1'b1;
                end
            end
            check("seq_done", 32'(done), 32'd1);
            check("seq_frame_pulses", 32'(n_frame), 32'd1);
            check("seq_beats", 32'(got.size()), 32'(frame_words(WS, FL)));
            for (int k = 0; k < exp_w.size() && k < got.size(); k++)
                check($sformatf("seq_word%0d", k), 32'(got[k]), 32'(exp_w[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
